// File: rtl/pdp8l_bus_frontend.sv
// Cleans up the raw PDP-8/L memory-start / IOP lines: synchronise, deglitch, and turn
// accepted edges into single-cycle pulses with the matching MA/MB/AC values captured.
module pdp8l_bus_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 5,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        _mem_start,
  input  logic [11:0] ma_in,
  input  logic [11:0] mb_in,
  input  logic [11:0] ac_in,
  input  logic [2:0]  iop_in,
  input  logic        _mwdone,
  output logic        memstart,
  output logic [11:0] memaddr,
  output logic [11:0] memwdat,
  output logic        iopstart,
  output logic        iopstop,
  output logic [11:0] ioopcode,
  output logic [11:0] cputodev,
  output logic        membusy,
  output logic        memtimeout
);

  localparam int RAW_W = 40;
  localparam int TW    = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] M_IDLE = 2'd0;
  localparam logic [1:0] M_WAIT = 2'd1;
  localparam logic [1:0] M_DONE = 2'd2;

  localparam logic [0:0] I_IDLE   = 1'b0;
  localparam logic [0:0] I_ACTIVE = 1'b1;

  // Inactive levels: memory start idles high, IOPs idle low.
  localparam logic [3:0] CTRL_IDLE = 4'b0001;

  // The synchroniser is deliberately left out of reset so that, by the time RESET is
  // released, it already holds the real line levels and armed cannot be fooled.
  logic [RAW_W-1:0] sync_reg [SYNC_STAGES];
  logic [RAW_W-1:0] synced;

  always_ff @(posedge CLOCK) begin
    sync_reg[0] <= {_mem_start, iop_in, ac_in, mb_in, ma_in};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign synced = sync_reg[SYNC_STAGES-1];

  logic        mem_start_s;
  logic [2:0]  iop_s;
  logic [11:0] ac_s;
  logic [11:0] mb_s;
  logic [11:0] ma_s;
  logic [3:0]  ctrl_s;

  assign mem_start_s = synced[39];
  assign iop_s       = synced[38:36];
  assign ac_s        = synced[35:24];
  assign mb_s        = synced[23:12];
  assign ma_s        = synced[11:0];
  assign ctrl_s      = {iop_s, mem_start_s};

  // Bit 0 is _mem_start, bits 3:1 are IOP1/IOP2/IOP4.
  logic [3:0] rise;
  logic [3:0] fall;
  logic       mem_level;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_filter
      logic       level_reg;
      logic [3:0] cnt_reg;
      logic       differ;
      logic       accept;

      assign differ = ctrl_s[gi] != level_reg;
      // Level flips on the FILTER-th consecutive disagreeing sample, and the edge event
      // is reported in that same cycle so downstream pulses add no extra latency.
      assign accept = differ && (cnt_reg == 4'(FILTER - 1));
      assign rise[gi] = accept && ctrl_s[gi];
      assign fall[gi] = accept && !ctrl_s[gi];

      always_ff @(posedge CLOCK) begin
        if (RESET) begin
          level_reg <= CTRL_IDLE[gi];
          cnt_reg   <= '0;
        end else if (!differ) begin
          cnt_reg   <= '0;
        end else if (accept) begin
          level_reg <= ctrl_s[gi];
          cnt_reg   <= '0;
        end else begin
          cnt_reg   <= cnt_reg + 4'd1;
        end
      end

      if (gi == 0) begin : g_mem_level
        assign mem_level = level_reg;
      end
    end
  endgenerate

  // armed only sets once the line has actually been seen high after reset.
  logic armed_reg;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      armed_reg <= 1'b0;
    end else if (mem_level && mem_start_s) begin
      armed_reg <= 1'b1;
    end
  end

  logic [1:0]    mstate_reg;
  logic [TW-1:0] tmo_cnt_reg;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mstate_reg  <= M_IDLE;
      tmo_cnt_reg <= '0;
      memstart    <= 1'b0;
      memaddr     <= '0;
      memwdat     <= '0;
      memtimeout  <= 1'b0;
    end else begin
      memstart <= 1'b0;
      case (mstate_reg)
        M_IDLE: begin
          if (fall[0] && armed_reg) begin
            memaddr     <= ma_s;
            memstart    <= 1'b1;
            tmo_cnt_reg <= '0;
            mstate_reg  <= M_WAIT;
          end
        end
        M_WAIT: begin
          memwdat <= mb_s;
          if (!_mwdone) begin
            mstate_reg <= M_DONE;
          end else if (tmo_cnt_reg == TW'(MEM_TIMEOUT - 1)) begin
            memtimeout <= 1'b1;
            mstate_reg <= M_DONE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        M_DONE: begin
          if (mem_level) begin
            mstate_reg <= M_IDLE;
          end
        end
        default: mstate_reg <= M_IDLE;
      endcase
    end
  end

  assign membusy = (mstate_reg != M_IDLE);

  logic [2:0] iop_rise;
  logic [2:0] iop_fall;
  logic [2:0] pick;

  assign iop_rise = rise[3:1];
  assign iop_fall = fall[3:1];

  // Simultaneous rises resolve to the lowest-numbered IOP.
  always_comb begin
    pick = 3'b000;
    if (iop_rise[0]) begin
      pick = 3'b001;
    end else if (iop_rise[1]) begin
      pick = 3'b010;
    end else if (iop_rise[2]) begin
      pick = 3'b100;
    end
  end

  logic [0:0] istate_reg;
  logic [2:0] active_reg;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      istate_reg <= I_IDLE;
      active_reg <= '0;
      iopstart   <= 1'b0;
      iopstop    <= 1'b0;
      ioopcode   <= '0;
      cputodev   <= '0;
    end else begin
      iopstart <= 1'b0;
      iopstop  <= 1'b0;
      case (istate_reg)
        I_IDLE: begin
          if (|pick) begin
            ioopcode   <= {mb_s[11:3], pick};
            cputodev   <= ac_s;
            iopstart   <= 1'b1;
            active_reg <= pick;
            istate_reg <= I_ACTIVE;
          end
        end
        I_ACTIVE: begin
          if (|(iop_fall & active_reg)) begin
            iopstop    <= 1'b1;
            istate_reg <= I_IDLE;
          end
        end
        default: istate_reg <= I_IDLE;
      endcase
    end
  end

endmodule
